// File: rtl/sdp_ram_pkg.sv
// Shared types and elaboration helpers for the simple-dual-port RAM and its clear sequencer.
package sdp_ram_pkg;

    typedef enum logic {
        RDW_OLD,
        RDW_NEW
    } rdw_mode_e;

    typedef enum logic {
        INIT,
        READY
    } init_state_e;

    function automatic int num_lanes(input int mem_width, input int byte_width);
        return mem_width / byte_width;
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Clear sequencer: after reset walks clrAddr over every word, then releases the RAM for user traffic.
module ram_init_ctrl
    import sdp_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 8,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          clrEn,
    output logic [AW-1:0] clrAddr,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    init_state_e   r_state;
    init_state_e   w_next_state;
    logic [AW-1:0] r_clr_addr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (clrEn) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    // NOTE: next-state gets its default first so no path through the block can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (r_state == INIT && r_clr_addr == LAST_ADDR) begin
            w_next_state = READY;
        end
    end

    assign clrEn   = (r_state == INIT) && !rst;
    assign clrAddr = r_clr_addr;
    assign busy    = (r_state == INIT);

endmodule

// File: rtl/sdp_ram.sv
// Simple-dual-port RAM with byte-lane writes, selectable read-during-write result,
// a 1- or 2-stage read pipeline and a post-reset clear sequence.
module sdp_ram
    import sdp_ram_pkg::*;
#(
    parameter int                   MEM_WIDTH  = 8,
    parameter int                   MEM_DEPTH  = 8,
    parameter int                   BYTE_WIDTH = 8,
    parameter int                   RD_LATENCY = 1,
    parameter rdw_mode_e            RDW_MODE   = RDW_OLD,
    parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      wrEn,
    input  logic [num_lanes(MEM_WIDTH, BYTE_WIDTH)-1:0] wrBe,
    input  logic [$clog2(MEM_DEPTH)-1:0]              wrAddr,
    input  logic [MEM_WIDTH-1:0]                      wrData,
    input  logic                                      rdEn,
    input  logic [$clog2(MEM_DEPTH)-1:0]              rdAddr,
    output logic [MEM_WIDTH-1:0]                      rdData,
    output logic                                      rdValid,
    output logic                                      initBusy
);

    localparam int            NUM_LANES = num_lanes(MEM_WIDTH, BYTE_WIDTH);
    localparam int            AW        = $clog2(MEM_DEPTH);
    localparam logic [AW:0]   DEPTH_LIM = (AW + 1)'(MEM_DEPTH);

    generate
        if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
            $error("sdp_ram: RD_LATENCY must be 1 or 2");
        end
        if (MEM_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
            $error("sdp_ram: MEM_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (MEM_DEPTH < 2) begin : g_bad_depth
            $error("sdp_ram: MEM_DEPTH must be at least 2");
        end
    endgenerate

    logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                 w_clr_en;
    logic [AW-1:0]        w_clr_addr;
    logic                 w_busy;

    ram_init_ctrl #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_init_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clrEn   (w_clr_en),
        .clrAddr (w_clr_addr),
        .busy    (w_busy)
    );

    assign initBusy = w_busy;

    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic [MEM_WIDTH-1:0] w_lane_mask;
    logic [MEM_WIDTH-1:0] w_rd_word;
    logic                 w_port_en;
    logic [AW-1:0]        w_port_addr;
    logic [NUM_LANES-1:0] w_port_be;
    logic [MEM_WIDTH-1:0] w_port_data;

    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_lane_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{wrBe[i]}};
        end

        w_wr_ok = wrEn && !w_busy && !rst && ({1'b0, wrAddr} < DEPTH_LIM);
        w_rd_ok = rdEn && !w_busy && !rst;

        // The clear sequencer owns the write port whenever it is active.
        w_port_en   = w_clr_en || w_wr_ok;
        w_port_addr = w_clr_en ? w_clr_addr : wrAddr;
        w_port_be   = w_clr_en ? '1 : wrBe;
        w_port_data = w_clr_en ? INIT_VALUE : wrData;

        w_rd_word = INIT_VALUE;
        if ({1'b0, rdAddr} < DEPTH_LIM) begin
            w_rd_word = r_mem[rdAddr];
            if (RDW_MODE == RDW_NEW && w_wr_ok && rdAddr == wrAddr) begin
                w_rd_word = (w_rd_word & ~w_lane_mask) | (wrData & w_lane_mask);
            end
        end
    end

    // NOTE: the array has no reset; the clear sequencer initialises it, which keeps it mappable to block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_port_en && w_port_be[i]) begin
                r_mem[w_port_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_port_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    logic                 r_rd_valid1;
    logic                 r_rd_valid2;
    logic [MEM_WIDTH-1:0] r_rd_data1;
    logic [MEM_WIDTH-1:0] r_rd_data2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid1 <= 1'b0;
            r_rd_valid2 <= 1'b0;
            r_rd_data1  <= INIT_VALUE;
            r_rd_data2  <= INIT_VALUE;
        end else begin
            r_rd_valid1 <= w_rd_ok;
            r_rd_valid2 <= r_rd_valid1;
            if (w_rd_ok) begin
                r_rd_data1 <= w_rd_word;
            end
            if (r_rd_valid1) begin
                r_rd_data2 <= r_rd_data1;
            end
        end
    end

    assign rdData  = (RD_LATENCY == 2) ? r_rd_data2  : r_rd_data1;
    assign rdValid = (RD_LATENCY == 2) ? r_rd_valid2 : r_rd_valid1;

endmodule

// File: tb/tb_sdp_ram.sv
// Bench for sdp_ram: two configurations share one stimulus stream and are checked every cycle
// against a behavioural model, plus literal expectations for the directed scenarios.
module tb_sdp_ram;
    import sdp_ram_pkg::*;

    logic        clk;
    logic        rst;
    logic        wrEn;
    logic [3:0]  wrBe;
    logic [2:0]  wrAddr;
    logic [31:0] wrData;
    logic        rdEn;
    logic [2:0]  rdAddr;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        busy_a, busy_b;

    int n_err = 0;
    int n_chk = 0;

    // Instance A: 6 words, 2-cycle reads, new-data read-during-write, clears to A5A5A5A5.
    sdp_ram #(
        .MEM_WIDTH  (32),
        .MEM_DEPTH  (6),
        .BYTE_WIDTH (8),
        .RD_LATENCY (2),
        .RDW_MODE   (RDW_NEW),
        .INIT_VALUE (32'hA5A5A5A5)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .wrBe     (wrBe),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .rdEn     (rdEn),
        .rdAddr   (rdAddr),
        .rdData   (rd_data_a),
        .rdValid  (rd_valid_a),
        .initBusy (busy_a)
    );

    // Instance B: 8 words, 1-cycle reads, old-data read-during-write, clears to zero.
    sdp_ram #(
        .MEM_WIDTH  (32),
        .MEM_DEPTH  (8),
        .BYTE_WIDTH (8),
        .RD_LATENCY (1),
        .RDW_MODE   (RDW_OLD),
        .INIT_VALUE (32'h0)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .wrBe     (wrBe),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .rdEn     (rdEn),
        .rdAddr   (rdAddr),
        .rdData   (rd_data_b),
        .rdValid  (rd_valid_b),
        .initBusy (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int dep(input int k);
        return (k == 0) ? 6 : 8;
    endfunction
    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction
    function automatic logic [31:0] initv(input int k);
        return (k == 0) ? 32'hA5A5A5A5 : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    typedef struct {
        int          k;
        int          due;
        logic [31:0] data;
    } rd_item_t;

    rd_item_t    pend[$];
    logic [31:0] m_mem [2][8];
    int          m_clear_left [2];
    logic [31:0] exp_data [2];
    logic        exp_valid [2];
    logic        exp_busy [2];
    bit          model_live = 0;
    int          cyc = 0;

    always @(posedge clk) begin
        rd_item_t    keep[$];
        logic [31:0] v;
        logic [31:0] merged;
        bit          wr_ok;
        cyc++;
        if (rst) begin
            model_live = 1;
            pend.delete();
            for (int k = 0; k < 2; k++) begin
                m_clear_left[k] = dep(k);
                exp_data[k]     = initv(k);
                exp_valid[k]    = 1'b0;
                exp_busy[k]     = 1'b1;
            end
        end else if (model_live) begin
            for (int k = 0; k < 2; k++) begin
                exp_valid[k] = 1'b0;
                if (m_clear_left[k] > 0) begin
                    m_mem[k][dep(k) - m_clear_left[k]] = initv(k);
                    m_clear_left[k]--;
                end else begin
                    wr_ok  = wrEn && (int'(wrAddr) < dep(k));
                    merged = wr_ok ? merge(m_mem[k][wrAddr], wrData, wrBe) : 32'h0;
                    if (rdEn) begin
                        v = (int'(rdAddr) >= dep(k)) ? initv(k) : m_mem[k][rdAddr];
                        if (k == 0 && wr_ok && rdAddr == wrAddr) v = merged;
                        pend.push_back('{k, cyc + lat(k) - 1, v});
                    end
                    if (wr_ok) m_mem[k][wrAddr] = merged;
                end
                exp_busy[k] = (m_clear_left[k] > 0);
            end
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    exp_valid[pend[i].k] = 1'b1;
                    exp_data[pend[i].k]  = pend[i].data;
                end else if (pend[i].due > cyc) begin
                    keep.push_back(pend[i]);
                end
            end
            pend = keep;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("A initBusy", 32'(busy_a), 32'(exp_busy[0]));
            check("A rdValid", 32'(rd_valid_a), 32'(exp_valid[0]));
            check("A rdData", rd_data_a, exp_data[0]);
            check("B initBusy", 32'(busy_b), 32'(exp_busy[1]));
            check("B rdValid", 32'(rd_valid_b), 32'(exp_valid[1]));
            check("B rdData", rd_data_b, exp_data[1]);
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic idle_inputs();
        wrEn = 1'b0; rdEn = 1'b0; wrBe = 4'h0; wrAddr = '0; wrData = '0; rdAddr = '0;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        wrEn = 1'b1; wrAddr = addr; wrData = data; wrBe = be; rdEn = 1'b0;
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    // Issues one read (optionally with a same-cycle write to the same address) and captures each result.
    task automatic do_read(input bit with_wr, input logic [2:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output logic [31:0] da, output logic [31:0] db);
        bit ga = 0, gb = 0;
        da = 'x; db = 'x;
        @(negedge clk);
        rdEn = 1'b1; rdAddr = addr;
        wrEn = with_wr; wrAddr = addr; wrData = data; wrBe = be;
        @(negedge clk);
        rdEn = 1'b0; wrEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (!ga && rd_valid_a) begin ga = 1; da = rd_data_a; end
            if (!gb && rd_valid_b) begin gb = 1; db = rd_data_b; end
            if (ga && gb) break;
            @(negedge clk);
        end
        check("A read completes", 32'(ga), 32'd1);
        check("B read completes", 32'(gb), 32'd1);
    endtask

    // Drops rst at the current negedge and counts busy cycles; hold_req keeps requests asserted meanwhile.
    task automatic count_clear(input bit hold_req, output int cnt_a, output int cnt_b,
                               output int bad_a, output int bad_b);
        cnt_a = 0; cnt_b = 0; bad_a = 0; bad_b = 0;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            if (busy_a && rd_valid_a) bad_a++;
            if (busy_b && rd_valid_b) bad_b++;
            if (hold_req && (busy_a || busy_b)) begin
                wrEn = 1'b1; rdEn = 1'b1; wrAddr = 3'd7; wrBe = 4'hF;
                wrData = $urandom(); rdAddr = 3'($urandom());
            end else begin
                wrEn = 1'b0; rdEn = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] da, db;
        int ca, cb, ba, bb;
        int first, last, n, consec;
        logic [31:0] got [4];

        rst = 1'b1;
        idle_inputs();

        // Reset and clear with requests held high throughout.
        @(negedge clk);
        wrEn = 1'b1; rdEn = 1'b1; wrAddr = 3'd7; wrBe = 4'hF;
        @(negedge clk);
        check("A busy after reset", 32'(busy_a), 32'd1);
        check("A rdData after reset", rd_data_a, 32'hA5A5A5A5);
        check("B rdData after reset", rd_data_b, 32'h0);
        count_clear(1'b1, ca, cb, ba, bb);
        check("A clear cycles", 32'(ca), 32'd6);
        check("B clear cycles", 32'(cb), 32'd8);
        check("A rdValid while busy", 32'(ba), 32'd0);
        check("B rdValid while busy", 32'(bb), 32'd0);

        for (int a = 0; a < 8; a++) begin
            do_read(1'b0, 3'(a), 32'h0, 4'h0, da, db);
            check($sformatf("A cleared word %0d", a), da, 32'hA5A5A5A5);
            check($sformatf("B cleared word %0d", a), db, 32'h0);
        end

        // Byte-lane write.
        do_write(3'd3, 32'h11223344, 4'b0101);
        do_read(1'b0, 3'd3, 32'h0, 4'h0, da, db);
        check("A byte lanes", da, 32'hA522A544);
        check("B byte lanes", db, 32'h00220044);

        // Same-address read during write.
        do_write(3'd2, 32'hAAAAAAAA, 4'hF);
        do_read(1'b1, 3'd2, 32'h55555555, 4'b0011, da, db);
        check("A rdw new", da, 32'hAAAA5555);
        check("B rdw old", db, 32'hAAAAAAAA);
        do_read(1'b0, 3'd2, 32'h0, 4'h0, da, db);
        check("A after rdw", da, 32'hAAAA5555);
        check("B after rdw", db, 32'hAAAA5555);

        // Back-to-back reads through the 2-stage pipeline.
        for (int a = 0; a < 4; a++) do_write(3'(a), 32'(10 + a), 4'hF);
        first = -1; last = -1; n = 0; consec = 1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (rd_valid_a) begin
                if (first < 0) first = j;
                else if (j != last + 1) consec = 0;
                last = j;
                if (n < 4) got[n] = rd_data_a;
                n++;
            end
            if (j < 4) begin rdEn = 1'b1; rdAddr = 3'(j); end
            else rdEn = 1'b0;
        end
        check("A burst first valid", 32'(first), 32'd2);
        check("A burst count", 32'(n), 32'd4);
        check("A burst contiguous", 32'(consec), 32'd1);
        for (int i = 0; i < 4; i++) check($sformatf("A burst data %0d", i), got[i], 32'(10 + i));

        // Out-of-range access on the 6-word instance.
        do_write(3'd7, 32'hDEADBEEF, 4'hF);
        do_read(1'b0, 3'd7, 32'h0, 4'h0, da, db);
        check("A oob read", da, 32'hA5A5A5A5);
        check("B addr7 read", db, 32'hDEADBEEF);
        do_read(1'b0, 3'd5, 32'h0, 4'h0, da, db);
        check("A addr5 untouched", da, 32'hA5A5A5A5);
        check("B addr5 untouched", db, 32'h0);
        do_read(1'b0, 3'd1, 32'h0, 4'h0, da, db);
        check("A addr1 untouched", da, 32'd11);

        // Reset while a 2-cycle read is in flight.
        do_write(3'd4, 32'h12345678, 4'hF);
        @(negedge clk);
        rdEn = 1'b1; rdAddr = 3'd4;
        @(negedge clk);
        rdEn = 1'b0; rst = 1'b1;
        @(negedge clk);
        count_clear(1'b0, ca, cb, ba, bb);
        check("A clear cycles after mid reset", 32'(ca), 32'd6);
        check("B clear cycles after mid reset", 32'(cb), 32'd8);
        check("A in-flight read dropped", 32'(ba), 32'd0);
        do_read(1'b0, 3'd4, 32'h0, 4'h0, da, db);
        check("A re-cleared word", da, 32'hA5A5A5A5);
        check("B re-cleared word", db, 32'h0);

        // Random traffic with occasional resets, checked by the model every cycle.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 249) == 0);
            wrEn   = 1'($urandom_range(0, 1));
            wrBe   = 4'($urandom());
            wrAddr = 3'($urandom());
            wrData = $urandom();
            rdEn   = 1'($urandom_range(0, 1));
            rdAddr = ($urandom_range(0, 3) == 0) ? wrAddr : 3'($urandom());
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
